// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide sequencer.
//   - op_e    : operation encodings driven on the `op` port
//   - state_e : sequencer FSM states
//   - DEFAULT_WIDTH : default operand width
//   - op_is_div / op_is_signed : decode helpers for op_e
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide loop.
//   mode_div   : 0 = shift-add multiply step, 1 = restoring divide step
//   acc        : current accumulator (product high half / partial remainder)
//   opnd       : multiplicand magnitude / divisor magnitude
//   shreg      : multiplier shift register / dividend-quotient shift register
//   acc_next   : accumulator after this step
//   shreg_next : shift register after this step
// The add or trial subtract is done at WIDTH+1 bits so the carry (multiply)
// or borrow (divide) is visible.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] shreg,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    sum        = '0;
    shifted    = '0;
    acc_next   = acc;
    shreg_next = shreg;
    if (mode_div) begin
      // Bring the next dividend bit into the partial remainder and trial
      // subtract; a borrow (top bit set) means the divisor did not fit.
      shifted = {acc, shreg[WIDTH-1]};
      sum     = shifted - {1'b0, opnd};
      if (sum[WIDTH]) begin
        acc_next   = shifted[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end else begin
        acc_next   = sum[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Add the multiplicand when the multiplier LSB is set, then shift the
      // {carry, acc, shreg} chain right by one.
      sum        = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply/divide sequencer for the execute stage.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   op           : 00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   src_a, src_b : multiplicand/dividend, multiplier/divisor
//   flush        : abort to IDLE (ignored in IDLE)
//   busy         : stall request, high in PREP/RUN/FIX
//   done         : one-cycle result-valid pulse (DONE state)
//   hi, lo       : product high/low word, or remainder/quotient
//   div_zero     : last divide had a zero divisor
// Signed operations run on magnitudes; signs are reapplied in FIX.
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;        // operands as captured on the accepting edge
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res;    // negate product / quotient in FIX
  logic               neg_rem;    // negate remainder in FIX
  logic [CNT_W-1:0]   count;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   shreg_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);

  // Magnitudes of the captured operands; the most negative value maps to
  // itself, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  assign prod     = {acc, shreg};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -shreg : shreg;
  assign rem_fix  = neg_rem ? -acc : acc;

  assign busy = (state == PREP) || (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode_div   (is_div),
    .acc        (acc),
    .opnd       (opnd),
    .shreg      (shreg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the datapath registers are reset along with the FSM so the
      // result outputs read zero after reset rather than stale values.
      state    <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (flush && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= PREP;
            op_q     <= op_e'(op);
            a_q      <= src_a;
            b_q      <= src_b;
            div_zero <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          if (is_div && (b_q == '0)) begin
            hi       <= a_q;
            lo       <= '1;
            div_zero <= 1'b1;
            state    <= DONE;
          end else begin
            acc     <= '0;
            shreg   <= a_mag;
            opnd    <= b_mag;
            neg_res <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem <= is_signed && a_q[WIDTH-1];
            count   <= CNT_W'(WIDTH - 1);
            state   <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          shreg <= shreg_next;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: self-checking bench for alu_muldiv_seq.
// Expected results are pushed onto a scoreboard queue when an operation is
// issued and popped when the DUT pulses done. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           lat;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model built on the simulator's own 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t             e;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sq;
    logic signed [63:0] sr;
    logic [63:0]      p;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = d;
    return e;
  endfunction

  // Called on a falling edge: drives start for one cycle and returns on the
  // falling edge of cycle N+1, with the operand inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Starts in cycle N+1 (cyc = 1); returns on the falling edge where done is
  // seen or when the budget expires. busy_ok is cleared if busy was low in
  // any cycle before done.
  task automatic wait_done(input int budget, output int cyc, output bit busy_ok);
    cyc     = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < budget) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
               busy, done, hi, lo, div_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Spec vectors plus random operations, all checked through the scoreboard.
  task automatic test_results();
    vec_t tbl[$];
    vec_t v;
    exp_t e;
    int   cyc;
    bit   bok;
    tbl.push_back('{2'b00, 32'hFFFFFFFD, 32'd7, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0), 35});
    tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'hFFFFFFFE, 32'h00000001, 1'b0), 35});
    tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0), 35});
    tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, mk(32'h0, 32'h80000000, 1'b0), 35});
    tbl.push_back('{2'b11, 32'h00001234, 32'h0, mk(32'h1234, 32'hFFFFFFFF, 1'b1), 2});
    tbl.push_back('{2'b11, 32'd10, 32'd3, mk(32'd1, 32'd3, 1'b0), 35});
    tbl.push_back('{2'b10, 32'd7, 32'hFFFFFFFE, mk(32'd1, 32'hFFFFFFFD, 1'b0), 35});
    for (int i = 0; i < 12; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a  = (i == 2) ? 32'h80000000 : $urandom;
      v.b  = (i == 5) ? 32'h0 : ((i == 7) ? 32'h80000000 : $urandom);
      v.e  = model(v.op, v.a, v.b);
      v.lat = (v.op[1] && v.b == '0) ? 2 : 35;
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      checks++;
      if (div_zero !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_accept: div_zero=%b busy=%b, required 0 and 1", i, div_zero, busy);
      end
      wait_done(60, cyc, bok);
      checks++;
      if (done !== 1'b1 || cyc != tbl[i].lat || !bok) begin
        errors++;
        $display("FAIL vec%0d_timing: done=%b at cycle %0d busy_ok=%b, required done at %0d busy_ok=1",
                 i, done, cyc, bok, tbl[i].lat);
      end
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_result: hi=%h lo=%h dz=%b busy=%b, required hi=%h lo=%h dz=%b busy=0",
                 i, hi, lo, div_zero, busy, e.hi, e.lo, e.dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_after: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    issue(2'b01, 32'h00010000, 32'h00030000, mk(32'd3, 32'd0, 1'b0));
    for (int c = 1; c < 35; c++) begin
      start = (c == 1 || c == 4 || c == 20 || c == 34);
      op = 2'b11; src_a = 32'd5; src_b = 32'd0;
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
      errors++;
      $display("FAIL start_ignored: done=%b hi=%h lo=%h dz=%b, required done=1 hi=%h lo=%h dz=%b",
               done, hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    exp_t e;
    int   cyc;
    bit   bok;
    int   seen;
    issue(2'b00, 32'd5, 32'd6, mk(32'd0, 32'd30, 1'b0));
    wait_done(60, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL flush_prev: done=%b hi=%h lo=%h, required 1 %h %h", done, hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    // MUL aborted at N+10; its expectation is discarded.
    issue(2'b00, 32'h00001111, 32'h00002222, mk(32'h0, 32'h0246_8642, 1'b0));
    void'(exp_q.pop_back());
    for (int c = 1; c < 10; c++) begin
      start = (c == 3);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd30) begin
      errors++;
      $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 1e",
               busy, done, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_quiet: %0d busy/done cycles after flush, required 0", seen);
    end
    // In IDLE flush does nothing, so a simultaneous start is accepted.
    flush = 1'b1;
    issue(2'b00, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0));
    flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: busy=%b, required 1", busy);
    end
    wait_done(60, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != 35 || lo !== e.lo || hi !== e.hi) begin
      errors++;
      $display("FAIL flush_idle_result: done=%b cycle=%0d hi=%h lo=%h, required 1 35 %h %h",
               done, cyc, hi, lo, e.hi, e.lo);
    end
    // In DONE, flush outranks start.
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL flush_over_start: busy=%b done=%b lo=%h, required 0 0 6", busy, done, lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   bok;
    issue(2'b00, 32'h00000123, 32'hFFFFFF00, model(2'b00, 32'h00000123, 32'hFFFFFF00));
    wait_done(60, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != 35 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL b2b_first: done=%b cycle=%0d hi=%h lo=%h, required 1 35 %h %h",
               done, cyc, hi, lo, e.hi, e.lo);
    end
    issue(2'b11, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_prep: done=%b busy=%b, required 0 1", done, busy);
    end
    wait_done(60, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != 35 || !bok || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL b2b_second: done=%b cycle=%0d busy_ok=%b hi=%h lo=%h, required 1 35 1 %h %h",
               done, cyc, bok, hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    bit   bok;
    issue(2'b01, 32'hDEADBEEF, 32'h00000011, model(2'b01, 32'hDEADBEEF, 32'h00000011));
    void'(exp_q.pop_back());
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
               busy, done, hi, lo, div_zero);
    end
    // Reset in the DONE cycle of a divide-by-zero clears div_zero as well.
    issue(2'b11, 32'h00ABCDEF, 32'h0, mk(32'h00ABCDEF, 32'hFFFFFFFF, 1'b1));
    wait_done(10, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != 2 || div_zero !== e.dz || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL reset_dz_setup: done=%b cycle=%0d dz=%b hi=%h lo=%h, required 1 2 1 %h %h",
               done, cyc, div_zero, hi, lo, e.hi, e.lo);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
               busy, done, hi, lo, div_zero);
    end
    issue(2'b10, 32'hFFFFFF9C, 32'd7, model(2'b10, 32'hFFFFFF9C, 32'd7));
    wait_done(60, cyc, bok);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != 35 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL reset_recover: done=%b cycle=%0d hi=%h lo=%h, required 1 35 %h %h",
               done, cyc, hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_results();
    test_start_ignored();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
